// File: rtl/spi_slave_device_if.sv
// Bus bundle for the SPI slave: serial pins plus the parallel TX/RX side.
// RX_ACK exists only when SPI_SLAVE_OVERRUN_EN is defined.
interface spi_slave_device_if #(
    parameter int DATA_W = 16
);
    logic              SCK;
    logic              CSbar;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_WE;
    logic              TX_READY;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_VALID;
    logic              ABORT;
    logic              UNDERRUN;
    logic              OVR;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic              RX_ACK;

    modport master (
        output SCK, CSbar, MOSI, TX_DATA, TX_WE, RX_ACK,
        input  MISO, TX_READY, RX_DATA, RX_VALID,
        input  ABORT, UNDERRUN, OVR
    );

    modport slave (
        input  SCK, CSbar, MOSI, TX_DATA, TX_WE, RX_ACK,
        output MISO, TX_READY, RX_DATA, RX_VALID,
        output ABORT, UNDERRUN, OVR
    );
`else
    modport master (
        output SCK, CSbar, MOSI, TX_DATA, TX_WE,
        input  MISO, TX_READY, RX_DATA, RX_VALID,
        input  ABORT, UNDERRUN, OVR
    );

    modport slave (
        input  SCK, CSbar, MOSI, TX_DATA, TX_WE,
        output MISO, TX_READY, RX_DATA, RX_VALID,
        output ABORT, UNDERRUN, OVR
    );
`endif
endinterface

// File: rtl/spi_slave_device.sv
// Oversampled 16-bit SPI slave: MSB first, MOSI on SCK rise, MISO on SCK fall.
// Optional RX overrun tracking (RX_ACK, OVR) under SPI_SLAVE_OVERRUN_EN.
module spi_slave_device #(
    parameter int                DATA_W      = 16,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = '0
) (
    input logic                CLK,
    input logic                RST_N,
    spi_slave_device_if.slave  bus
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_hist_q, sck_hist_d;
    logic                   cs_hist_q, cs_hist_d;
    logic [DATA_W-1:0]      shadow_q, shadow_d;
    logic                   full_q, full_d;
    logic [DATA_W-1:0]      sh_out_q, sh_out_d;
    logic [DATA_W-1:0]      sh_in_q, sh_in_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   miso_q, miso_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   abort_q, abort_d;
    logic                   underrun_q, underrun_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [DATA_W-1:0]      load_word;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                   unread_q, unread_d;
    logic                   ovr_q, ovr_d;
`endif

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s & sck_hist_q;
    assign cs_rise  = cs_s & ~cs_hist_q;
    assign cs_fall  = ~cs_s & cs_hist_q;
    assign load_word = full_q ? shadow_q : TX_IDLE;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.CSbar};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
        sck_hist_d  = sck_s;
        cs_hist_d   = cs_s;
        state_d     = state_q;
        shadow_d    = shadow_q;
        full_d      = full_q;
        sh_out_d    = sh_out_q;
        sh_in_d     = sh_in_q;
        rx_data_d   = rx_data_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        abort_d     = 1'b0;
        underrun_d  = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        unread_d    = unread_q & ~bus.RX_ACK;
        ovr_d       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    miso_d  = 1'b0;
                end else begin
                    sh_out_d   = load_word;
                    full_d     = 1'b0;
                    underrun_d = ~full_q;
                    miso_d     = load_word[DATA_W-1];
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    miso_d  = 1'b0;
                end else if (cnt_q == CW'(DATA_W)) begin
                    state_d    = DONE;
                    rx_data_d  = sh_in_q;
                    rx_valid_d = 1'b1;
                    miso_d     = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
                    ovr_d      = unread_q & ~bus.RX_ACK;
                    unread_d   = 1'b1;
`endif
                end else if (sck_rise) begin
                    sh_in_d = {sh_in_q[DATA_W-2:0], mosi_s};
                    cnt_d   = cnt_q + CW'(1);
                end else if (sck_fall && cnt_q != '0) begin
                    sh_out_d = {sh_out_q[DATA_W-2:0], 1'b0};
                    miso_d   = sh_out_q[DATA_W-2];
                end
            end
            DONE: begin
                // zero-fill until the master releases CSbar
                miso_d = 1'b0;
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a write in the LOAD cycle lands after the old word was taken
        if (bus.TX_WE) begin
            shadow_d = bus.TX_DATA;
            full_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b0;
            cs_hist_q   <= 1'b1;
            shadow_q    <= '0;
            full_q      <= 1'b0;
            sh_out_q    <= '0;
            sh_in_q     <= '0;
            rx_data_q   <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            abort_q     <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            unread_q    <= 1'b0;
            ovr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_hist_q  <= sck_hist_d;
            cs_hist_q   <= cs_hist_d;
            shadow_q    <= shadow_d;
            full_q      <= full_d;
            sh_out_q    <= sh_out_d;
            sh_in_q     <= sh_in_d;
            rx_data_q   <= rx_data_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            abort_q     <= abort_d;
            underrun_q  <= underrun_d;
`ifdef SPI_SLAVE_OVERRUN_EN
            unread_q    <= unread_d;
            ovr_q       <= ovr_d;
`endif
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.TX_READY = ~full_q;
    assign bus.RX_DATA  = rx_data_q;
    assign bus.RX_VALID = rx_valid_q;
    assign bus.ABORT    = abort_q;
    assign bus.UNDERRUN = underrun_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign bus.OVR      = ovr_q;
`else
    assign bus.OVR      = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_device.sv
// Self-checking bench for spi_slave_device: frame table plus corner sequences.
// Received words are scoreboarded; pulse outputs are counted by a monitor.
module tb_spi_slave_device;
    localparam int DW = 16;
    localparam int SS = 2;

    typedef struct {
        logic [DW-1:0] mosi;
        logic          tx_en;
        logic [DW-1:0] tx_word;
        logic [DW-1:0] exp_miso;
        int            exp_under;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    spi_slave_device_if #(.DATA_W(DW)) bus ();

    spi_slave_device #(
        .DATA_W(DW),
        .SYNC_STAGES(SS),
        .TX_IDLE(16'h0000)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_abort = 0;
    int n_under = 0;
    int n_ovr = 0;
    logic [DW-1:0] rx_got[$];
    logic [DW-1:0] exp_q[$];

    always @(negedge CLK) begin
        if (bus.RX_VALID) begin
            n_valid <= n_valid + 1;
            rx_got.push_back(bus.RX_DATA);
        end
        if (bus.ABORT)    n_abort <= n_abort + 1;
        if (bus.UNDERRUN) n_under <= n_under + 1;
        if (bus.OVR)      n_ovr <= n_ovr + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic tx_write(input logic [DW-1:0] w);
        bus.TX_DATA = w;
        bus.TX_WE   = 1'b1;
        tick(1);
        bus.TX_WE   = 1'b0;
    endtask

`ifdef SPI_SLAVE_OVERRUN_EN
    task automatic rx_ack();
        bus.RX_ACK = 1'b1;
        tick(1);
        bus.RX_ACK = 1'b0;
    endtask
`endif

    task automatic sb_check(input string nm);
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_got.size() == 0) begin
                errors++;
                $display("FAIL %s rx_data: got none expected %h", nm, e);
            end else begin
                g = rx_got.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s rx_data: got %h expected %h", nm, g, e);
                end
            end
        end
        checks++;
        if (rx_got.size() != 0) begin
            errors++;
            $display("FAIL %s rx_extra: got %0d words expected 0", nm,
                     rx_got.size());
            rx_got.delete();
        end
    endtask

    // SCK = CLK/8; MISO is sampled just before each rising SCK edge
    task automatic frame(input logic [DW-1:0] mosi, input int nrise,
                         input int rst_at, output logic [DW:0] miso_bits,
                         output int miso_lat, output int rx_lat);
        miso_bits = '0;
        miso_lat  = -1;
        rx_lat    = -1;
        bus.CSbar = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (bus.MISO === 1'b1 && miso_lat < 0) miso_lat = c;
        end
        tick(1);
        for (int i = 0; i < nrise; i++) begin
            if (i == rst_at) begin
                chk("pre_reset_miso", 32'(bus.MISO), 32'd1);
                tx_write(16'hBEEF);
                chk("pre_reset_tx_ready", 32'(bus.TX_READY), 32'd0);
                RST_N = 1'b0;
                #1;
                chk("rst_mid_miso", 32'(bus.MISO), 32'd0);
                chk("rst_mid_rx_valid", 32'(bus.RX_VALID), 32'd0);
                chk("rst_mid_tx_ready", 32'(bus.TX_READY), 32'd1);
                chk("rst_mid_rx_data", 32'(bus.RX_DATA), 32'd0);
                bus.SCK   = 1'b0;
                bus.CSbar = 1'b1;
                bus.MOSI  = 1'b0;
                tick(3);
                RST_N = 1'b1;
                tick(8);
                return;
            end
            bus.MOSI = (i < DW) ? mosi[DW-1-i] : 1'b0;
            tick(4);
            miso_bits = {miso_bits[DW-1:0], bus.MISO};
            bus.SCK = 1'b1;
            if (i == DW - 1) begin
                for (int c = 1; c <= 8; c++) begin
                    @(posedge CLK);
                    @(negedge CLK);
                    if (bus.RX_VALID === 1'b1 && rx_lat < 0) rx_lat = c;
                end
                tick(1);
            end else begin
                tick(4);
            end
            bus.SCK = 1'b0;
        end
        tick(4);
        bus.CSbar = 1'b1;
        tick(8);
    endtask

    vec_t vecs[4];
    int v0, a0, u0, o0;
    int ml, rl;
    logic [DW:0] mb;
    logic [DW-1:0] prev_rx;

    initial begin
        vecs[0] = '{16'h1234, 1'b1, 16'hA5C3, 16'hA5C3, 0};
        vecs[1] = '{16'h5A5A, 1'b0, 16'h0000, 16'h0000, 1};
        vecs[2] = '{16'h8001, 1'b1, 16'hFFFF, 16'hFFFF, 0};
        vecs[3] = '{16'h0000, 1'b1, 16'h7E81, 16'h7E81, 0};

        bus.SCK = 1'b0;
        bus.CSbar = 1'b1;
        bus.MOSI = 1'b0;
        bus.TX_DATA = '0;
        bus.TX_WE = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        bus.RX_ACK = 1'b0;
`endif
        tick(3);
        chk("reset_miso", 32'(bus.MISO), 32'd0);
        chk("reset_tx_ready", 32'(bus.TX_READY), 32'd1);
        chk("reset_rx_data", 32'(bus.RX_DATA), 32'd0);
        chk("reset_rx_valid", 32'(bus.RX_VALID), 32'd0);
        chk("reset_abort", 32'(bus.ABORT), 32'd0);
        chk("reset_underrun", 32'(bus.UNDERRUN), 32'd0);
        chk("reset_ovr", 32'(bus.OVR), 32'd0);
        RST_N = 1'b1;
        tick(4);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].tx_en) begin
                tx_write(vecs[i].tx_word);
                chk("tx_ready_after_we", 32'(bus.TX_READY), 32'd0);
            end
            exp_q.push_back(vecs[i].mosi);
            v0 = n_valid;
            u0 = n_under;
            frame(vecs[i].mosi, DW, -1, mb, ml, rl);
            chk("vec_miso_stream", 32'(mb[DW-1:0]), 32'(vecs[i].exp_miso));
            chk("vec_underrun", 32'(n_under - u0), 32'(vecs[i].exp_under));
            chk("vec_rx_valid_cnt", 32'(n_valid - v0), 32'd1);
            chk("vec_tx_ready_idle", 32'(bus.TX_READY), 32'd1);
            sb_check("vec");
            if (i == 0) begin
                chk("miso_latency", 32'(ml), 32'(SS + 2));
                chk("rx_valid_latency", 32'(rl), 32'(SS + 2));
            end
        end

        // last write wins in the shadow register
        tx_write(16'h1111);
        tx_write(16'h2222);
        chk("tx_ready_overwrite", 32'(bus.TX_READY), 32'd0);
        exp_q.push_back(16'h3333);
        frame(16'h3333, DW, -1, mb, ml, rl);
        chk("overwrite_miso", 32'(mb[DW-1:0]), 32'h2222);
        sb_check("overwrite");

        // abort after 9 rising edges
        prev_rx = bus.RX_DATA;
        v0 = n_valid;
        a0 = n_abort;
        frame(16'hABCD, 9, -1, mb, ml, rl);
        chk("abort_pulse", 32'(n_abort - a0), 32'd1);
        chk("abort_no_valid", 32'(n_valid - v0), 32'd0);
        chk("abort_rx_hold", 32'(bus.RX_DATA), 32'(prev_rx));
        sb_check("abort");
        exp_q.push_back(16'hFFFF);
        frame(16'hFFFF, DW, -1, mb, ml, rl);
        sb_check("after_abort");

        // trailing 17th SCK pulse is ignored
        tx_write(16'h8001);
        v0 = n_valid;
        exp_q.push_back(16'hC3A5);
        frame(16'hC3A5, DW + 1, -1, mb, ml, rl);
        chk("extra_pulse_miso", 32'(mb), {15'd0, 16'h8001, 1'b0});
        chk("extra_pulse_valid", 32'(n_valid - v0), 32'd1);
        sb_check("extra_pulse");

        // reset at bit 7, then a clean frame
        tx_write(16'hFFFF);
        frame(16'h3C3C, DW, 7, mb, ml, rl);
        rx_got.delete();
        u0 = n_under;
        exp_q.push_back(16'h0F0F);
        frame(16'h0F0F, DW, -1, mb, ml, rl);
        chk("post_reset_miso", 32'(mb[DW-1:0]), 32'h0000);
        chk("post_reset_underrun", 32'(n_under - u0), 32'd1);
        sb_check("post_reset");

`ifdef SPI_SLAVE_OVERRUN_EN
        rx_ack();
        o0 = n_ovr;
        exp_q.push_back(16'h0001);
        frame(16'h0001, DW, -1, mb, ml, rl);
        exp_q.push_back(16'h0002);
        frame(16'h0002, DW, -1, mb, ml, rl);
        chk("ovr_no_ack", 32'(n_ovr - o0), 32'd1);
        chk("ovr_rx_data", 32'(bus.RX_DATA), 32'h0002);
        sb_check("ovr");
        rx_ack();
        o0 = n_ovr;
        exp_q.push_back(16'h0003);
        frame(16'h0003, DW, -1, mb, ml, rl);
        rx_ack();
        exp_q.push_back(16'h0004);
        frame(16'h0004, DW, -1, mb, ml, rl);
        chk("ovr_with_ack", 32'(n_ovr - o0), 32'd0);
        sb_check("ovr_ack");
`else
        chk("ovr_tied_low", 32'(n_ovr), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_device.md
Name: spi_slave_device

Overview:
- SPI slave (responder) for the 16-bit SPI master link, used on the peripheral or loop-back side.
- Oversamples SCK, CSbar and MOSI on the system clock and deserialises MOSI into a parallel word.
- Serialises a preloaded transmit word onto MISO.
- Uses the same framing as the master: CSbar active low, MSB first, MOSI sampled on SCK rising, MISO updated on SCK falling.

Parameters:
- DATA_W, 16, frame length in bits, and width of RX_DATA and TX_DATA.
- SYNC_STAGES, 2, number of synchroniser flops on SCK, CSbar and MOSI (minimum 2).
- TX_IDLE, 16'h0000, word shifted out when no transmit word is loaded at frame start.

Ports:
- CLK, input, 1, system clock; must run at 4x or more the SCK frequency.
- RST_N, input, 1, reset; asynchronous assert, active low.
- SCK, input, 1, SPI clock from master.
- CSbar, input, 1, chip select from master, active low.
- MOSI, input, 1, serial data from master.
- MISO, output, 1, serial data to master.
- TX_DATA, input, DATA_W, word to transmit in the next frame.
- TX_WE, input, 1, one-CLK strobe; loads TX_DATA into the transmit shadow register.
- TX_READY, output, 1, high when the shadow register is empty.
- RX_DATA, output, DATA_W, last complete received word; held until the next complete frame.
- RX_VALID, output, 1, one-CLK pulse when RX_DATA updates.
- ABORT, output, 1, one-CLK pulse when CSbar deasserts mid-frame.
- UNDERRUN, output, 1, one-CLK pulse when a frame starts with the shadow register empty.
- OVR, output, 1, overrun flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active low (RST_N).
- Reset values:
  - MISO=0, TX_READY=1, RX_DATA=0, RX_VALID=0, ABORT=0, UNDERRUN=0, OVR=0.
  - Shadow register empty, bit counter 0, state IDLE.
- Synchronisation and edge detect:
  - SCK, CSbar and MOSI each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - An SCK or CSbar event is acted on exactly SYNC_STAGES+1 CLK cycles after the pin changes.
- States:
  - IDLE → LOAD: on CSbar falling. MOSI and MISO activity while CSbar is high is ignored.
  - LOAD (one cycle):
    - Shift-out register ← shadow if full, else TX_IDLE. Shadow becomes empty and TX_READY goes to 1.
    - If the shadow was empty, UNDERRUN pulses.
    - MISO ← MSB of the shift-out register. Bit counter ← 0.
    - Go to SHIFT.
  - SHIFT:
    - On SCK rising: shift-in register ← {shift-in[DATA_W-2:0], MOSI_sync}; counter += 1.
    - On SCK falling, when counter is between 1 and DATA_W-1: shift out the next bit onto MISO.
    - When counter reaches DATA_W → DONE.
  - DONE:
    - Entry cycle: RX_DATA ← shift-in, RX_VALID pulses.
    - Further SCK edges are ignored and MISO is driven 0; this matches the master's zero-fill after its last bit.
    - CSbar rising → IDLE.
  - Mid-frame CSbar rising (in LOAD or SHIFT): go to IDLE and pulse ABORT. RX_DATA is unchanged, no RX_VALID, and the partial transmit word is discarded.
- Transmit handshake:
  - TX_WE with TX_READY=1: shadow ← TX_DATA; TX_READY=0 on the next cycle.
  - TX_WE with TX_READY=0: overwrites the shadow (last write wins).
  - TX_WE in the same cycle as LOAD: LOAD takes the old shadow contents (or TX_IDLE), then the new word is stored and TX_READY=0.
- Latency:
  - RX_VALID rises SYNC_STAGES+2 CLK cycles after the DATA_W-th SCK rising edge.
  - The first MISO bit is valid SYNC_STAGES+2 CLK cycles after CSbar falls.
- CSbar falling in DONE or IDLE always starts a fresh frame.
- Asserting RST_N mid-frame returns every output to its reset value immediately. The frame in progress is lost.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined:
  - A sticky RX_UNREAD bit sets on RX_VALID and clears on RX_ACK, a one-CLK input port present only under the macro.
  - If RX_VALID fires while RX_UNREAD=1, OVR pulses for one cycle. RX_DATA is still overwritten.
- Not defined: no RX_ACK port, and OVR is tied 0.

Test Plan:
1. Reset release, then TX_WE with TX_DATA=16'hA5C3, then a 16-bit frame with MOSI=16'h1234 at SCK=CLK/8 → RX_DATA=16'h1234, one RX_VALID pulse, MISO bit stream = A5C3 MSB first, TX_READY returns to 1 at LOAD.
2. Frame with no TX_WE beforehand → MISO stream = TX_IDLE (0000), UNDERRUN pulses once, RX still correct.
3. CSbar rises after 9 SCK rising edges → ABORT pulse, no RX_VALID, RX_DATA keeps its previous value. The next full frame with MOSI=16'hFFFF → RX_DATA=16'hFFFF.
4. 17 SCK pulses in one frame (master-style trailing edge) → RX_DATA = the first 16 bits only, MISO=0 after bit 16, exactly one RX_VALID.
5. RST_N pulsed low at bit 7 of a frame → MISO, RX_VALID and TX_READY immediately at reset values. A subsequent clean frame 16'h0F0F is received correctly.
6. With SPI_SLAVE_OVERRUN_EN defined: two back-to-back frames 16'h0001 then 16'h0002 with no RX_ACK → OVR pulses on the second RX_VALID and RX_DATA=16'h0002. A repeat with RX_ACK between the frames → OVR stays 0.
